// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch/decode boundary.
package if_id_queue_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_entry_t;

    function automatic logic [31:0] sat_add32(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/ifq_perf_counters.sv
// Saturating occupancy and flush-loss counters for the IF/ID queue.
module ifq_perf_counters
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [PTR_W:0]   i_count,
    input  logic             i_flush,
    output logic [31:0]      o_full_cycles,
    output logic [31:0]      o_empty_cycles,
    output logic [31:0]      o_flush_drops
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0] r_full;
    logic [31:0] r_empty;
    logic [31:0] r_drops;
    logic        w_full;
    logic        w_empty;

    assign w_full  = (i_count == FULL_CNT);
    assign w_empty = (i_count == '0);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_full  <= '0;
            r_empty <= '0;
            r_drops <= '0;
        end else begin
            if (w_full)
                r_full <= sat_add32(r_full, 32'd1);
            if (w_empty)
                r_empty <= sat_add32(r_empty, 32'd1);
            if (i_flush)
                r_drops <= sat_add32(r_drops, 32'(i_count));
        end
    end

    assign o_full_cycles  = r_full;
    assign o_empty_cycles = r_empty;
    assign o_flush_drops  = r_drops;

endmodule

// File: rtl/if_id_queue.sv
// Circular IF->ID decoupling queue with redirect flush.
// Optional perf counters enabled by defining IFQ_PERF_CNT_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter int          PTR_W    = $clog2(DEPTH),
    parameter logic [31:0] NOP_INST = if_id_queue_pkg::NOP_INST
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      IF_Inst,
    input  logic [31:0]      IF_PC,
    input  logic             IF_valid,
    input  logic             Flush,
    input  logic             ID_stall,
    output logic             IF_stall,
    output logic [31:0]      ID_Inst,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_PC4,
    output logic             ID_valid,
`ifdef IFQ_PERF_CNT_EN
    output logic [31:0]      perf_full_cycles,
    output logic [31:0]      perf_empty_cycles,
    output logic [31:0]      perf_flush_drops,
`endif
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    if_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_valid;
    logic               w_full;
    logic               w_deq;
    logic               w_enq;
    if_entry_t          w_head;
    logic [31:0]        w_pc;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_deq   = w_valid & ~ID_stall;
    // A full queue still accepts when the head leaves this same cycle.
    assign w_enq   = IF_valid & ~Flush & (~w_full | w_deq);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count
                     + {{PTR_W{1'b0}}, w_enq}
                     - {{PTR_W{1'b0}}, w_deq};
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset && w_enq) begin
            r_mem[r_wr_ptr].inst <= IF_Inst;
            r_mem[r_wr_ptr].pc   <= IF_PC;
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign w_pc     = w_valid ? w_head.pc : 32'h0;

    assign ID_valid = w_valid;
    assign ID_Inst  = w_valid ? w_head.inst : NOP_INST;
    assign ID_PC    = w_pc;
    assign ID_PC4   = w_pc + PC_INC;
    assign IF_stall = w_full & ID_stall & ~Flush;
    assign count    = r_count;

`ifdef IFQ_PERF_CNT_EN
    ifq_perf_counters #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_perf (
        .CLK            (CLK),
        .Reset          (Reset),
        .i_count        (r_count),
        .i_flush        (Flush),
        .o_full_cycles  (perf_full_cycles),
        .o_empty_cycles (perf_empty_cycles),
        .o_flush_drops  (perf_flush_drops)
    );
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2).
module tb_if_id_queue;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] IF_Inst;
    logic [31:0] IF_PC;
    logic        IF_valid;
    logic        Flush;
    logic        ID_stall;
    logic        IF_stall;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC;
    logic [31:0] ID_PC4;
    logic        ID_valid;
    logic [1:0]  count;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_empty_cycles;
    logic [31:0] perf_flush_drops;
    logic [31:0] drops_before;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    if_id_queue #(.DEPTH(2)) dut (
        .CLK               (CLK),
        .Reset             (Reset),
        .IF_Inst           (IF_Inst),
        .IF_PC             (IF_PC),
        .IF_valid          (IF_valid),
        .Flush             (Flush),
        .ID_stall          (ID_stall),
        .IF_stall          (IF_stall),
        .ID_Inst           (ID_Inst),
        .ID_PC             (ID_PC),
        .ID_PC4            (ID_PC4),
        .ID_valid          (ID_valid),
`ifdef IFQ_PERF_CNT_EN
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles),
        .perf_flush_drops  (perf_flush_drops),
`endif
        .count             (count)
    );

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        IF_valid = 1'b1;
        IF_PC    = pc;
        IF_Inst  = mk_inst(pc);
    endtask

    task automatic test_reset();
        Reset = 1'b1; IF_valid = 1'b0; Flush = 1'b0; ID_stall = 1'b0;
        IF_PC = 32'h0; IF_Inst = 32'h0;
        step(); step();
        Reset = 1'b0;
        #1;
        n_checks++;
        if (ID_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid got=%0b exp=0", ID_valid);
        end
        n_checks++;
        if (ID_Inst !== 32'h0) begin
            n_fail++; $display("FAIL rst_inst got=%h exp=00000000", ID_Inst);
        end
        n_checks++;
        if (ID_PC !== 32'h0 || ID_PC4 !== 32'h4) begin
            n_fail++; $display("FAIL rst_pc got=%h/%h exp=0/4", ID_PC, ID_PC4);
        end
        n_checks++;
        if (count !== 2'd0 || IF_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_cnt got=%0d/%0b exp=0/0", count, IF_stall);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3] = '{32'h00, 32'h04, 32'h08};
        ID_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch(pcs[i]);
            step();
            n_checks++;
            if (ID_PC !== pcs[i] || count !== 2'd1 || ID_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream%0d got pc=%h cnt=%0d v=%0b exp pc=%h cnt=1 v=1",
                         i, ID_PC, count, ID_valid, pcs[i]);
            end
            n_checks++;
            if (ID_Inst !== mk_inst(pcs[i]) || ID_PC4 !== pcs[i] + 32'd4) begin
                n_fail++;
                $display("FAIL stream_data%0d got %h/%h exp %h/%h", i,
                         ID_Inst, ID_PC4, mk_inst(pcs[i]), pcs[i] + 32'd4);
            end
        end
        IF_valid = 1'b0;
        step();
        n_checks++;
        if (count !== 2'd0 || ID_valid !== 1'b0 || ID_Inst !== 32'h0) begin
            n_fail++;
            $display("FAIL stream_drain got cnt=%0d v=%0b inst=%h exp 0/0/0",
                     count, ID_valid, ID_Inst);
        end
    endtask

    task automatic test_fill();
        ID_stall = 1'b1;
        fetch(32'h10); step();
        n_checks++;
        if (count !== 2'd1 || IF_stall !== 1'b0) begin
            n_fail++; $display("FAIL fill1 got cnt=%0d st=%0b exp 1/0", count, IF_stall);
        end
        fetch(32'h14); step();
        n_checks++;
        if (count !== 2'd2 || IF_stall !== 1'b1) begin
            n_fail++; $display("FAIL fill2 got cnt=%0d st=%0b exp 2/1", count, IF_stall);
        end
        fetch(32'h18); step();
        n_checks++;
        if (count !== 2'd2 || ID_PC !== 32'h10) begin
            n_fail++; $display("FAIL fill_hold got cnt=%0d pc=%h exp 2/10", count, ID_PC);
        end
        ID_stall = 1'b0;
        #1;
        n_checks++;
        if (IF_stall !== 1'b0) begin
            n_fail++; $display("FAIL fill_release_stall got=%0b exp=0", IF_stall);
        end
        step();
        n_checks++;
        if (count !== 2'd2 || ID_PC !== 32'h14) begin
            n_fail++; $display("FAIL fill_out2 got cnt=%0d pc=%h exp 2/14", count, ID_PC);
        end
        IF_valid = 1'b0;
        step();
        n_checks++;
        if (count !== 2'd1 || ID_PC !== 32'h18 || ID_Inst !== mk_inst(32'h18)) begin
            n_fail++; $display("FAIL fill_out3 got cnt=%0d pc=%h exp 1/18", count, ID_PC);
        end
        step();
        n_checks++;
        if (count !== 2'd0) begin
            n_fail++; $display("FAIL fill_empty got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_flush_full();
        ID_stall = 1'b1;
        fetch(32'h30); step();
        fetch(32'h34); step();
`ifdef IFQ_PERF_CNT_EN
        drops_before = perf_flush_drops;
`endif
        Flush = 1'b1;
        fetch(32'h20);
        #1;
        n_checks++;
        if (IF_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall got=%0b exp=0", IF_stall);
        end
        step();
        Flush = 1'b0;
        IF_valid = 1'b0;
        n_checks++;
        if (count !== 2'd0 || ID_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear got cnt=%0d v=%0b exp 0/0", count, ID_valid);
        end
`ifdef IFQ_PERF_CNT_EN
        n_checks++;
        if (perf_flush_drops !== drops_before + 32'd2) begin
            n_fail++; $display("FAIL flush_drops got=%0d exp=%0d",
                               perf_flush_drops, drops_before + 32'd2);
        end
`endif
        step();
        n_checks++;
        if (count !== 2'd0 || ID_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_noenq got cnt=%0d v=%0b exp 0/0", count, ID_valid);
        end
        ID_stall = 1'b0;
        fetch(32'h24); step();
        Flush = 1'b1; IF_valid = 1'b0;
        step();
        Flush = 1'b0;
        n_checks++;
        if (count !== 2'd0 || ID_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_deq got cnt=%0d v=%0b exp 0/0", count, ID_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] feed [3] = '{32'h58, 32'h5C, 32'h60};
        logic [31:0] head [3] = '{32'h54, 32'h58, 32'h5C};
        ID_stall = 1'b1;
        fetch(32'h50); step();
        fetch(32'h54); step();
        ID_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch(feed[i]);
            step();
            n_checks++;
            if (count !== 2'd2 || IF_stall !== 1'b0 || ID_PC !== head[i]) begin
                n_fail++;
                $display("FAIL b2b%0d got cnt=%0d st=%0b pc=%h exp 2/0/%h",
                         i, count, IF_stall, ID_PC, head[i]);
            end
        end
        IF_valid = 1'b0;
        step();
        n_checks++;
        if (count !== 2'd1 || ID_PC !== 32'h60) begin
            n_fail++; $display("FAIL b2b_tail got cnt=%0d pc=%h exp 1/60", count, ID_PC);
        end
        step();
    endtask

    task automatic test_empty_stall();
        ID_stall = 1'b1; IF_valid = 1'b0;
        step(); step();
        n_checks++;
        if (count !== 2'd0 || ID_valid !== 1'b0 || IF_stall !== 1'b0) begin
            n_fail++; $display("FAIL empty_stall got cnt=%0d v=%0b st=%0b exp 0/0/0",
                               count, ID_valid, IF_stall);
        end
        fetch(32'h90); step();
        IF_valid = 1'b0;
        n_checks++;
        if (ID_valid !== 1'b1 || ID_PC !== 32'h90 || count !== 2'd1) begin
            n_fail++; $display("FAIL empty_stall_enq got v=%0b pc=%h cnt=%0d exp 1/90/1",
                               ID_valid, ID_PC, count);
        end
        ID_stall = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        ID_stall = 1'b1;
        fetch(32'h70); step();
        fetch(32'h74); step();
        Reset = 1'b1;
        fetch(32'h78);
        step();
        Reset = 1'b0;
        IF_valid = 1'b0;
        n_checks++;
        if (count !== 2'd0 || ID_valid !== 1'b0 || ID_PC4 !== 32'h4) begin
            n_fail++; $display("FAIL rstmid got cnt=%0d v=%0b pc4=%h exp 0/0/4",
                               count, ID_valid, ID_PC4);
        end
        ID_stall = 1'b0;
        fetch(32'h40);
        step();
        IF_valid = 1'b0;
        n_checks++;
        if (ID_valid !== 1'b1 || ID_PC !== 32'h40 || count !== 2'd1) begin
            n_fail++; $display("FAIL rstmid_first got v=%0b pc=%h cnt=%0d exp 1/40/1",
                               ID_valid, ID_PC, count);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_flush_full();
        test_back_to_back();
        test_empty_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
